// File: rtl/switch_conditioner_pkg.sv
// switch_conditioner_pkg
//
// Shared definitions for the switch conditioning stage.
//   db_state_e              per-bit debounce state; bit 1 is the accepted (clean) level
//   DEFAULT_WIDTH           default number of switch bits (a, b, c)
//   DEFAULT_DEBOUNCE_CYCLES default stable-cycle count (10 ms at 50 MHz)
//   cnt_width()             width of the debounce counter for a given cycle count
//   level_of()              accepted level encoded in a state

package switch_conditioner_pkg;

   // Encoding chosen so that bit 1 is the accepted level: the clean output
   // and the rise/fall edges fall straight out of the state register.
   typedef enum logic [1:0] {
      STABLE_LOW  = 2'b00,
      WAIT_HIGH   = 2'b01,
      STABLE_HIGH = 2'b11,
      WAIT_LOW    = 2'b10
   } db_state_e;

   localparam int unsigned DEFAULT_WIDTH           = 3;
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

   // Counter only needs to reach cycles-1; keep at least one bit so the
   // degenerate single-cycle configuration still elaborates.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      int unsigned w;
      w = (cycles > 1) ? $clog2(cycles) : 1;
      return w;
   endfunction

   function automatic logic level_of(input db_state_e st);
      logic [1:0] enc;
      enc = st;
      return enc[1];
   endfunction

endpackage

// File: rtl/switch_conditioner_if.sv
// switch_conditioner_if
//
// Signal bundle between the raw switch source and the conditioning stage.
//   sw_in    raw asynchronous switch levels (driven by the source / master)
//   sw_clean debounced, synchronized levels
//   sw_rise  per-bit one-cycle pulse on a 0->1 clean transition
//   sw_fall  per-bit one-cycle pulse on a 1->0 clean transition
//   changed  OR of every rise and fall strobe
// master: the switch source and downstream consumer; slave: the conditioner.

interface switch_conditioner_if #(
   parameter int unsigned WIDTH = 3
);

   logic [WIDTH-1:0] sw_in;
   logic [WIDTH-1:0] sw_clean;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;
   logic             changed;

   modport master (
      output sw_in,
      input  sw_clean,
      input  sw_rise,
      input  sw_fall,
      input  changed
   );

   modport slave (
      input  sw_in,
      output sw_clean,
      output sw_rise,
      output sw_fall,
      output changed
   );

endinterface

// File: rtl/switch_conditioner_debounce_bit.sv
// debounce_bit
//
// Conditions a single raw switch bit: two-flop synchronizer, stable-cycle
// counter with a four-state machine, and registered rise/fall strobes.
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   raw    raw asynchronous switch level
//   clean  accepted level, changes only after DEBOUNCE_CYCLES stable samples
//   rise   one-cycle pulse in the first cycle clean reads 1
//   fall   one-cycle pulse in the first cycle clean reads 0

module debounce_bit
   import switch_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic clean,
   output logic rise,
   output logic fall
);

   localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Synchronizer; nothing else looks at raw.
   logic sync1_q;
   logic sync2_q;
   logic s;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;

   // Debounce state machine and counter.
   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             terminal;

   assign terminal = (cnt_q == TERMINAL);

   // cnt_d defaults to 0: every path that does not keep counting (level
   // matches, bounce back, or terminal count) must clear it.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         STABLE_LOW: begin
            if (s) begin
               // terminal is already true here when DEBOUNCE_CYCLES == 1
               if (terminal) begin
                  state_d = STABLE_HIGH;
               end else begin
                  state_d = WAIT_HIGH;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         WAIT_HIGH: begin
            if (!s) begin
               state_d = STABLE_LOW;
            end else if (terminal) begin
               state_d = STABLE_HIGH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STABLE_HIGH: begin
            if (!s) begin
               if (terminal) begin
                  state_d = STABLE_LOW;
               end else begin
                  state_d = WAIT_LOW;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         WAIT_LOW: begin
            if (s) begin
               state_d = STABLE_HIGH;
            end else if (terminal) begin
               state_d = STABLE_LOW;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = STABLE_LOW;
         end
      endcase
   end

   // Strobes are computed from the next state so they appear in the same
   // cycle the new clean level first becomes visible.
   logic rise_q;
   logic fall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= STABLE_LOW;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= ~level_of(state_q) &  level_of(state_d);
         fall_q  <=  level_of(state_q) & ~level_of(state_d);
      end
   end

   assign clean = level_of(state_q);
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/switch_conditioner.sv
// switch_conditioner
//
// Input conditioning stage in front of the truth-table labs. Each switch bit
// is synchronized and debounced independently; rise/fall/changed strobes let
// sequential labs react to switch events.
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    switch_conditioner_if.slave:
//            sw_in (raw levels, bit 2 = a, bit 1 = b, bit 0 = c),
//            sw_clean, sw_rise, sw_fall, changed
// All outputs come from registers; there is no combinational path from sw_in.

module switch_conditioner
   import switch_conditioner_pkg::*;
#(
   parameter int unsigned WIDTH           = DEFAULT_WIDTH,
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset,
   switch_conditioner_if.slave  bus
);

   logic [WIDTH-1:0] clean;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce_bit (
         .clk   (clk),
         .reset (reset),
         .raw   (bus.sw_in[i]),
         .clean (clean[i]),
         .rise  (rise[i]),
         .fall  (fall[i])
      );
   end

   assign bus.sw_clean = clean;
   assign bus.sw_rise  = rise;
   assign bus.sw_fall  = fall;
   // Simultaneous events on several bits collapse into one pulse.
   assign bus.changed  = |{rise, fall};

endmodule

// File: tb/tb_switch_conditioner.sv
module tb_switch_conditioner;

   localparam int unsigned W = 3;
   localparam int unsigned D = 4;

   logic clk = 1'b0;
   logic reset;

   switch_conditioner_if #(.WIDTH(W)) bus ();

   switch_conditioner #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
   endtask

   // Reference model: s is sw_in delayed two edges; a bit's clean level flips
   // at the edge where the last D observed s values (all since the latest
   // reset) disagree with it.
   logic [W-1:0] m_p1, m_p2, m_clean, m_rise, m_fall;
   logic [W-1:0] m_hist[$];

   task automatic model_edge(input logic [W-1:0] sw, input logic rst);
      logic [W-1:0] s;
      bit all_diff;
      if (rst) begin
         m_p1 = '0; m_p2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
         m_hist.delete();
      end else begin
         s = m_p2;
         m_p2 = m_p1;
         m_p1 = sw;
         m_hist.push_back(s);
         if (m_hist.size() > D) void'(m_hist.pop_front());
         m_rise = '0;
         m_fall = '0;
         if (m_hist.size() == D) begin
            for (int b = 0; b < W; b++) begin
               all_diff = 1;
               for (int j = 0; j < D; j++)
                  if (m_hist[j][b] == m_clean[b]) all_diff = 0;
               if (all_diff) begin
                  if (m_clean[b]) m_fall[b] = 1'b1;
                  else            m_rise[b] = 1'b1;
                  m_clean[b] = ~m_clean[b];
               end
            end
         end
      end
   endtask

   task automatic model_check(input string tag);
      check({tag, "_clean"},   16'(bus.sw_clean), 16'(m_clean));
      check({tag, "_rise"},    16'(bus.sw_rise),  16'(m_rise));
      check({tag, "_fall"},    16'(bus.sw_fall),  16'(m_fall));
      check({tag, "_changed"}, 16'(bus.changed),  16'(|{m_rise, m_fall}));
   endtask

   // Drive away from the active edge, advance the model on the edge, sample after it.
   task automatic step(input logic [W-1:0] sw, input logic rst);
      @(negedge clk);
      bus.sw_in = sw;
      reset     = rst;
      @(posedge clk);
      model_edge(sw, rst);
      #1;
   endtask

   typedef struct {
      logic [W-1:0] sw;
      logic         rst;
      logic [W-1:0] clean;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic         ch;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [W-1:0] sw, input logic rst, input logic [W-1:0] clean,
                      input logic [W-1:0] rise, input logic [W-1:0] fall, input logic ch);
      vec_t v;
      v.sw = sw; v.rst = rst; v.clean = clean; v.rise = rise; v.fall = fall; v.ch = ch;
      vecs.push_back(v);
   endtask

   task automatic add_hold(input logic [W-1:0] sw, input int n, input logic [W-1:0] clean);
      for (int i = 0; i < n; i++) add(sw, 1'b0, clean, '0, '0, 1'b0);
   endtask

   logic [W-1:0] sw;
   logic [4:0]   pat;
   int           first;
   int           pulses;

   initial begin
      bus.sw_in = '0;
      reset     = 1'b1;

      // Clean press, further presses, release, full release, simultaneous press.
      add(3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0);
      add(3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0);
      add_hold(3'b100, 5, 3'b000);
      add(3'b100, 1'b0, 3'b100, 3'b100, 3'b000, 1'b1);
      add_hold(3'b100, 2, 3'b100);
      add_hold(3'b111, 5, 3'b100);
      add(3'b111, 1'b0, 3'b111, 3'b011, 3'b000, 1'b1);
      add_hold(3'b111, 1, 3'b111);
      add_hold(3'b101, 5, 3'b111);
      add(3'b101, 1'b0, 3'b101, 3'b000, 3'b010, 1'b1);
      add_hold(3'b101, 1, 3'b101);
      add_hold(3'b000, 5, 3'b101);
      add(3'b000, 1'b0, 3'b000, 3'b000, 3'b101, 1'b1);
      add_hold(3'b000, 1, 3'b000);
      add_hold(3'b111, 5, 3'b000);
      add(3'b111, 1'b0, 3'b111, 3'b111, 3'b000, 1'b1);
      add_hold(3'b111, 1, 3'b111);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].sw, vecs[i].rst);
         check($sformatf("vec%0d_clean", i),   16'(bus.sw_clean), 16'(vecs[i].clean));
         check($sformatf("vec%0d_rise", i),    16'(bus.sw_rise),  16'(vecs[i].rise));
         check($sformatf("vec%0d_fall", i),    16'(bus.sw_fall),  16'(vecs[i].fall));
         check($sformatf("vec%0d_changed", i), 16'(bus.changed),  16'(vecs[i].ch));
      end

      // Bounce on bit 0: 1,0,1,0,1 then held 1. Last 0 reaches s two edges
      // after it is sampled, so four 1s at s complete at edge 9.
      step(3'b000, 1'b1);
      step(3'b000, 1'b1);
      step(3'b000, 1'b0);
      step(3'b000, 1'b0);
      pat    = 5'b10101;
      first  = -1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         sw = (i < 5) ? {2'b00, pat[i]} : 3'b001;
         step(sw, 1'b0);
         model_check("bounce");
         if (bus.sw_rise[0]) pulses++;
         if (first < 0 && bus.sw_clean[0]) first = i;
      end
      check("bounce_accept_edge", 16'(first), 16'd9);
      check("bounce_rise_pulses", 16'(pulses), 16'd1);

      // Reset on the second counting cycle, then full latency again.
      step(3'b000, 1'b1);
      step(3'b000, 1'b1);
      step(3'b000, 1'b0);
      step(3'b000, 1'b0);
      step(3'b001, 1'b0);
      step(3'b001, 1'b0);
      step(3'b001, 1'b0);
      step(3'b001, 1'b1);
      check("rst_mid_clean",   16'(bus.sw_clean), 16'd0);
      check("rst_mid_rise",    16'(bus.sw_rise),  16'd0);
      check("rst_mid_fall",    16'(bus.sw_fall),  16'd0);
      check("rst_mid_changed", 16'(bus.changed),  16'd0);
      first = -1;
      for (int i = 0; i < 10; i++) begin
         step(3'b001, 1'b0);
         model_check("rst_mid");
         if (first < 0 && bus.sw_clean == 3'b001) first = i;
      end
      check("rst_mid_accept_edge", 16'(first), 16'd5);

      // Randomized stimulus against the model.
      sw = '0;
      for (int i = 0; i < 600; i++) begin
         for (int b = 0; b < W; b++)
            if ($urandom_range(0, 5) == 0) sw[b] = ~sw[b];
         step(sw, ($urandom_range(0, 199) == 0));
         model_check("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
